fft_pipe_seq: RTL
=================

Name: fft_pipe_seq

Overview:
Sequencer for the radix-16 butterfly datapath: a chain of PIPE_DEPTH 16-lane x 64-bit register stages that advance together.
- Issues one 16-point group per cycle and tracks valid plus (stage, group) tags alongside the data.
- Drives a single advance enable shared by all register stages and handles downstream valid/ready backpressure.
- Enforces a barrier between FFT stages: the pipe drains fully before the next stage issues.
- Sits between the memory-address generator (consumes issue_*) and the write-back unit (consumes out_*).

Parameters:
PIPE_DEPTH, 4, number of datapath register stages (>=2)
GRP_W, 8, log2 of groups per FFT stage (256 groups = 4096-pt radix-16)
NUM_STAGE, 3, FFT stages per frame (>=1)
STG_W, 2, width of stage index (2^STG_W >= NUM_STAGE)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start_i  in  1  frame start; sampled only in IDLE
abort_i  in  1  synchronous abort; priority over everything except reset
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse, frame complete
pipe_en_o  out  1  advance enable for all datapath register stages
issue_valid_o  out  1  group entered pipe this cycle
issue_stage_o  out  STG_W  stage of issued group
issue_grp_o  out  GRP_W  index of issued group
out_valid_o  out  1  group present at pipe output
out_ready_i  in  1  downstream accepts
out_stage_o  out  STG_W  tag of output group
out_grp_o  out  GRP_W  tag of output group

Behaviour:
- Reset (rst_n=0 at a posedge): state=IDLE; vld shift register=0; all tags=0; stage and group counters=0. Every output is 0 except pipe_en_o, which is 1 (empty pipe).
- pipe_en_o = ~vld[PIPE_DEPTH-1] | out_ready_i. Combinational; out_ready_i to pipe_en_o and issue_valid_o is the only combinational path.
- Bubbles do not compress. The whole pipe freezes only while the output stage holds data that is not accepted.
- On pipe_en_o: vld <= {vld[D-2:0], issue_fire}. Tags shift identically.
- Tags of empty slots are don't-care; the bench checks them only when the slot is valid.
- out_valid_o = vld[PIPE_DEPTH-1]. Output fire = out_valid_o & out_ready_i.
- issue_valid_o = (state==ISSUE) & pipe_en_o. issue_stage_o and issue_grp_o come from the counters.
- Latency: with no stall, a group issued in cycle t shows out_valid_o in cycle t+PIPE_DEPTH.
- Each stall cycle adds one cycle of delay to every in-flight group.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start_i -> ISSUE with stage=0, grp=0.
  - ISSUE: each issue fire increments grp. Firing the last group (grp = 2^GRP_W-1) -> DRAIN and grp wraps to 0. No issue while pipe_en_o=0 (grp holds).
  - DRAIN: no issue. When vld==0: if stage==NUM_STAGE-1 -> DONE, else stage+1 -> ISSUE.
  - The vld==0 check uses the registered vld, so there is one idle cycle after the last output fire.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
- done_o and busy_o are decoded from registered state.
- start_i while busy: ignored, no queuing.
- start_i in the DONE cycle: ignored.
- abort_i in any state: next cycle state=IDLE, vld=0, counters=0, no done_o.
  - Outputs presented in the abort cycle are still valid for that cycle.
- Reset mid-frame: identical to abort, plus tags cleared.
- Simultaneous start_i and abort_i in IDLE: abort wins, stay IDLE.
- Counter widths: grp is GRP_W bits and wraps naturally. stage is STG_W bits and never exceeds NUM_STAGE-1.

Decomposition:
- Shared package fft_ctrl_pkg holds the state enum (IDLE/ISSUE/DRAIN/DONE) and the tag struct {stage[STG_W], grp[GRP_W]}. The same tag struct is used by the address generator and write-back.
- One sub-module, pipe_tag_shift: a PIPE_DEPTH-deep valid+tag shift register with enable and synchronous clear.
- The FSM and counters stay in fft_pipe_seq.

Test Plan:
All scenarios use PIPE_DEPTH=4, GRP_W=2, NUM_STAGE=2.
1. Nominal: out_ready_i=1, start_i pulse in cycle 0.
   -> issue_valid_o in cycles 1-4 (stage0, grp 0..3) and 10-13 (stage1, grp 0..3).
   -> out_valid_o in cycles 5-8 and 14-17 with matching tags.
   -> done_o only in cycle 19; busy_o high cycles 1-19.
2. Backpressure: as 1, but out_ready_i=0 in cycles 5-7.
   -> pipe_en_o=0 and no issue in cycles 5-7.
   -> stage0 grp0 output held in cycles 5-8.
   -> every later event shifts +3; done_o in cycle 22; no tag lost or duplicated.
3. Start while busy: start_i pulses in cycles 0 and 6.
   -> one frame only; done_o once, in cycle 19.
4. Abort: abort_i in cycle 11 (stage1 issuing).
   -> cycle 12: busy_o=0, out_valid_o=0, no done_o.
   -> new start_i in cycle 14 yields a full nominal frame, done_o in cycle 33.
5. Reset mid-DRAIN: rst_n=0 in cycle 7.
   -> cycle 8: all outputs 0, pipe_en_o=1, vld empty; state IDLE.
6. Stall at output during DRAIN: out_ready_i=0 in cycles 16-20.
   -> DRAIN holds; done_o in cycle 24; out_grp_o stays 2 throughout the stall.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared control types for the radix-16 FFT datapath: sequencer state and the
// (stage, group) tag carried next to the data by address-gen, pipe and write-back.
package fft_ctrl_pkg;

  localparam int unsigned TAG_STG_W = 2;
  localparam int unsigned TAG_GRP_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fft_state_t;

  typedef struct packed {
    logic [TAG_STG_W-1:0] stage;
    logic [TAG_GRP_W-1:0] grp;
  } fft_tag_t;

endpackage

// File: rtl/fft_pipe_seq_if.sv
// Handshake bundle of the FFT pipe sequencer: frame control, issue side toward the
// address generator, output side toward write-back.
interface fft_pipe_seq_if #(
  parameter int unsigned STG_W = 2,
  parameter int unsigned GRP_W = 8
);

  logic             start_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic             pipe_en_o;
  logic             issue_valid_o;
  logic [STG_W-1:0] issue_stage_o;
  logic [GRP_W-1:0] issue_grp_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [STG_W-1:0] out_stage_o;
  logic [GRP_W-1:0] out_grp_o;

  // master: the sequencer itself
  modport master (
    input  start_i, abort_i, out_ready_i,
    output busy_o, done_o, pipe_en_o,
    output issue_valid_o, issue_stage_o, issue_grp_o,
    output out_valid_o, out_stage_o, out_grp_o
  );

  // slave: frame controller / address generator / write-back side
  modport slave (
    output start_i, abort_i, out_ready_i,
    input  busy_o, done_o, pipe_en_o,
    input  issue_valid_o, issue_stage_o, issue_grp_o,
    input  out_valid_o, out_stage_o, out_grp_o
  );

endinterface

// File: rtl/pipe_tag_shift.sv
// Valid + tag shadow of the datapath register chain: shifts on the shared advance
// enable, clear drops all valids (tags only reset on rst_n).
module pipe_tag_shift #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  output logic [DEPTH-1:0] vld,
  output logic [TAG_W-1:0] out_tag
);

  logic [TAG_W-1:0] tag [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag[i] <= '0;
    end else if (clr) begin
      vld <= '0;
    end else if (en) begin
      vld    <= {vld[DEPTH-2:0], in_vld};
      tag[0] <= in_tag;
      for (int unsigned i = 1; i < DEPTH; i++) tag[i] <= tag[i-1];
    end
  end

  assign out_tag = tag[DEPTH-1];

endmodule

// File: rtl/fft_pipe_seq.sv
// Radix-16 datapath sequencer: issues one group per cycle, runs the shared pipe
// advance enable under output backpressure, and drains the pipe between FFT stages.
module fft_pipe_seq
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned GRP_W      = 8,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned STG_W      = 2
) (
  input logic            clk,
  input logic            rst_n,
  fft_pipe_seq_if.master bus
);

  localparam int unsigned TAG_W = STG_W + GRP_W;
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_STAGE - 1);

  // same field layout as fft_tag_t, sized by this instance's parameters
  typedef struct packed {
    logic [STG_W-1:0] stage;
    logic [GRP_W-1:0] grp;
  } tag_t;

  fft_state_t            state, state_nxt;
  logic [STG_W-1:0]      stage, stage_nxt;
  logic [GRP_W-1:0]      grp, grp_nxt;
  logic [PIPE_DEPTH-1:0] vld;
  tag_t                  in_tag, out_tag;
  logic                  pipe_en;
  logic                  issue_fire;

  // only a held, unaccepted output freezes the chain; bubbles are never squeezed out
  assign pipe_en    = ~vld[PIPE_DEPTH-1] | bus.out_ready_i;
  assign issue_fire = (state == ISSUE) & pipe_en;
  assign in_tag     = '{stage: stage, grp: grp};

  pipe_tag_shift #(
    .DEPTH (PIPE_DEPTH),
    .TAG_W (TAG_W)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bus.abort_i),
    .en      (pipe_en),
    .in_vld  (issue_fire),
    .in_tag  (in_tag),
    .vld     (vld),
    .out_tag (out_tag)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      stage <= '0;
      grp   <= '0;
    end else begin
      state <= state_nxt;
      stage <= stage_nxt;
      grp   <= grp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    grp_nxt   = grp;
    if (bus.abort_i) begin
      state_nxt = IDLE;
      stage_nxt = '0;
      grp_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            state_nxt = ISSUE;
            stage_nxt = '0;
            grp_nxt   = '0;
          end
        end
        ISSUE: begin
          if (issue_fire) begin
            grp_nxt = grp + 1'b1;
            if (grp == '1) state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          // registered vld: one idle cycle follows the final output fire
          if (vld == '0) begin
            if (stage == LAST_STAGE) begin
              state_nxt = DONE;
              stage_nxt = '0;
            end else begin
              state_nxt = ISSUE;
              stage_nxt = stage + 1'b1;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.busy_o        = (state != IDLE);
  assign bus.done_o        = (state == DONE);
  assign bus.pipe_en_o     = pipe_en;
  assign bus.issue_valid_o = issue_fire;
  assign bus.issue_stage_o = stage;
  assign bus.issue_grp_o   = grp;
  assign bus.out_valid_o   = vld[PIPE_DEPTH-1];
  assign bus.out_stage_o   = out_tag.stage;
  assign bus.out_grp_o     = out_tag.grp;

endmodule
